// File: rtl/brpuf_pkg.sv
// rtl/brpuf_pkg.sv - shared types and defaults for the bistable-ring PUF evaluation sequencer
package brpuf_pkg;

  localparam int CW                = 32;
  localparam int DEF_RESET_CYCLES  = 4;
  localparam int DEF_SETTLE_CYCLES = 16;
  localparam int DEF_NUM_EVAL      = 5;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    SETTLE,
    SAMPLE,
    DONE
  } state_e;

endpackage

// File: rtl/brpuf_eval_ctrl_if.sv
// rtl/brpuf_eval_ctrl_if.sv - host-side challenge request / response bundle
interface brpuf_eval_ctrl_if #(
  parameter int CW       = 32,
  parameter int NUM_EVAL = 5
);
  localparam int OCW = $clog2(NUM_EVAL + 1);

  logic           start;
  logic [CW-1:0]  challenge_in;
  logic           ready;
  logic           rsp_valid;
  logic           rsp_ready;
  logic           rsp;
  logic [OCW-1:0] ones_count;
  logic           unstable;

  modport master (
    output start, challenge_in, rsp_ready,
    input  ready, rsp_valid, rsp, ones_count, unstable
  );

  modport slave (
    input  start, challenge_in, rsp_ready,
    output ready, rsp_valid, rsp, ones_count, unstable
  );
endinterface

// File: rtl/brpuf_eval_ctrl_sync2.sv
// rtl/brpuf_eval_ctrl_sync2.sv - two-flop synchroniser for the asynchronous ring output
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);
  (* keep = "true" *) logic [1:0] ff_q;

  always_ff @(posedge clk) begin
    if (reset) ff_q <= 2'b00;
    else       ff_q <= {ff_q[0], d_i};
  end

  assign q_o = ff_q[1];
endmodule

// File: rtl/brpuf_eval_ctrl.sv
// rtl/brpuf_eval_ctrl.sv - reset/settle/sample sequencer with majority vote over NUM_EVAL ring evaluations
module brpuf_eval_ctrl
  import brpuf_pkg::*;
#(
  parameter int CW            = brpuf_pkg::CW,
  parameter int RESET_CYCLES  = DEF_RESET_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int NUM_EVAL      = DEF_NUM_EVAL
) (
  input  logic          clk,
  input  logic          reset,
  brpuf_eval_ctrl_if.slave host,
  output logic [CW-1:0] ring_challenge,
  output logic          ring_reset,
  input  logic          ring_rsp
);
  localparam int OCW  = $clog2(NUM_EVAL + 1);
  localparam int CMAX = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int CNTW = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CNTW-1:0] RST_LOAD    = CNTW'(RESET_CYCLES - 1);
  localparam logic [CNTW-1:0] SETTLE_LOAD = CNTW'(SETTLE_CYCLES - 1);

  state_e          state_q;
  logic [CNTW-1:0] cnt_q;
  logic [OCW-1:0]  eval_q, ones_q, ones_out_q;
  logic            ready_q, rsp_valid_q, rsp_q, unstable_q, ring_reset_q;
  logic [CW-1:0]   ring_chal_q;
  logic            smp;
  logic [OCW-1:0]  eval_d, ones_d;

  sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (ring_rsp),
    .q_o   (smp)
  );

  assign eval_d = eval_q + OCW'(1);
  assign ones_d = ones_q + OCW'(smp);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      eval_q       <= '0;
      ones_q       <= '0;
      ones_out_q   <= '0;
      ready_q      <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_q        <= 1'b0;
      unstable_q   <= 1'b0;
      ring_reset_q <= 1'b1;
      ring_chal_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (host.start) begin
          ring_chal_q <= host.challenge_in;
          eval_q      <= '0;
          ones_q      <= '0;
          cnt_q       <= RST_LOAD;
          ready_q     <= 1'b0;
          state_q     <= RST;
        end
        RST: begin
          if (cnt_q == '0) begin
            cnt_q        <= SETTLE_LOAD;
            ring_reset_q <= 1'b0;
            state_q      <= SETTLE;
          end else begin
            cnt_q <= cnt_q - CNTW'(1);
          end
        end
        SETTLE: begin
          if (cnt_q == '0) state_q <= SAMPLE;
          else             cnt_q   <= cnt_q - CNTW'(1);
        end
        SAMPLE: begin
          eval_q       <= eval_d;
          ones_q       <= ones_d;
          ring_reset_q <= 1'b1;
          if (eval_d < OCW'(NUM_EVAL)) begin
            cnt_q   <= RST_LOAD;
            state_q <= RST;
          end else begin
            // strict majority: an even-count tie votes 0
            rsp_q       <= ({ones_d, 1'b0} > (OCW + 1)'(NUM_EVAL));
            ones_out_q  <= ones_d;
            unstable_q  <= (ones_d != '0) && (ones_d != OCW'(NUM_EVAL));
            rsp_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: if (host.rsp_ready) begin
          rsp_valid_q <= 1'b0;
          ready_q     <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign host.ready      = ready_q;
  assign host.rsp_valid  = rsp_valid_q;
  assign host.rsp        = rsp_q;
  assign host.ones_count = ones_out_q;
  assign host.unstable   = unstable_q;
  assign ring_challenge  = ring_chal_q;
  assign ring_reset      = ring_reset_q;
endmodule

// File: tb/tb_brpuf_eval_ctrl.sv
// tb/tb_brpuf_eval_ctrl.sv - directed self-checking bench for brpuf_eval_ctrl
module tb_brpuf_eval_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  brpuf_eval_ctrl_if #(.CW(32), .NUM_EVAL(5)) h0 ();
  brpuf_eval_ctrl_if #(.CW(32), .NUM_EVAL(4)) h1 ();

  logic [31:0] r0_chal, r1_chal;
  logic        r0_reset, r1_reset;
  logic        r0_rsp = 1'b0;
  logic        r1_rsp = 1'b0;

  brpuf_eval_ctrl u0 (
    .clk (clk), .reset (reset), .host (h0.slave),
    .ring_challenge (r0_chal), .ring_reset (r0_reset), .ring_rsp (r0_rsp)
  );

  brpuf_eval_ctrl #(.NUM_EVAL(4)) u1 (
    .clk (clk), .reset (reset), .host (h1.slave),
    .ring_challenge (r1_chal), .ring_reset (r1_reset), .ring_rsp (r1_rsp)
  );

  // Ring models: each release of ring_reset starts a new evaluation that settles to pat[idx]
  logic pat0 [0:7];
  logic pat1 [0:7];
  int   idx0 = 0;
  int   idx1 = 0;

  always @(negedge r0_reset) begin
    r0_rsp = pat0[idx0];
    if (idx0 < 7) idx0 = idx0 + 1;
  end

  always @(negedge r1_reset) begin
    r1_rsp = pat1[idx1];
    if (idx1 < 7) idx1 = idx1 + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_pat0(input logic [4:0] p);
    for (int i = 0; i < 5; i++) pat0[i] = p[4-i];
    for (int i = 5; i < 8; i++) pat0[i] = 1'b0;
    idx0 = 0;
  endtask

  task automatic accept0(input logic [31:0] c);
    @(negedge clk);
    h0.start = 1'b1;
    h0.challenge_in = c;
    @(posedge clk);
    #1 h0.start = 1'b0;
  endtask

  task automatic wait_valid0(output int n, output int fall);
    n = 0;
    fall = -1;
    do begin
      @(posedge clk);
      #1 n++;
      if (fall < 0 && r0_reset === 1'b0) fall = n;
    end while (h0.rsp_valid !== 1'b1 && n < 400);
  endtask

  task automatic release0();
    @(negedge clk);
    h0.rsp_ready = 1'b1;
    @(posedge clk);
    #1 h0.rsp_ready = 1'b0;
  endtask

  initial begin
    int n, fall;
    h0.start = 1'b0; h0.challenge_in = '0; h0.rsp_ready = 1'b0;
    h1.start = 1'b0; h1.challenge_in = '0; h1.rsp_ready = 1'b0;
    set_pat0(5'b11111);
    for (int i = 0; i < 8; i++) pat1[i] = 1'b0;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_ready", 32'(h0.ready), 32'd1);
    chk("rst_rsp_valid", 32'(h0.rsp_valid), 32'd0);
    chk("rst_rsp", 32'(h0.rsp), 32'd0);
    chk("rst_ones", 32'(h0.ones_count), 32'd0);
    chk("rst_unstable", 32'(h0.unstable), 32'd0);
    chk("rst_ring_chal", r0_chal, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 chk("idle_ring_reset", 32'(r0_reset), 32'd1);
    end

    // stable-1 ring
    set_pat0(5'b11111);
    accept0(32'hA5A5_A5A5);
    chk("accept_ready_low", 32'(h0.ready), 32'd0);
    wait_valid0(n, fall);
    chk("latency", n, 32'd105);
    chk("ring_reset_fall", fall, 32'd4);
    chk("s1_rsp", 32'(h0.rsp), 32'd1);
    chk("s1_ones", 32'(h0.ones_count), 32'd5);
    chk("s1_unstable", 32'(h0.unstable), 32'd0);
    chk("s1_ring_chal", r0_chal, 32'hA5A5_A5A5);
    chk("s1_done_ring_reset", 32'(r0_reset), 32'd1);
    release0();
    chk("s1_back_ready", 32'(h0.ready), 32'd1);
    chk("s1_back_valid", 32'(h0.rsp_valid), 32'd0);
    chk("s1_hold_rsp", 32'(h0.rsp), 32'd1);

    // alternating ring 1,0,1,0,1
    set_pat0(5'b10101);
    accept0(32'h0F0F_0001);
    wait_valid0(n, fall);
    chk("alt_latency", n, 32'd105);
    chk("alt_rsp", 32'(h0.rsp), 32'd1);
    chk("alt_ones", 32'(h0.ones_count), 32'd3);
    chk("alt_unstable", 32'(h0.unstable), 32'd1);
    release0();

    // NUM_EVAL=4 tie 1,1,0,0
    pat1[0] = 1'b1; pat1[1] = 1'b1; pat1[2] = 1'b0; pat1[3] = 1'b0;
    idx1 = 0;
    @(negedge clk);
    h1.start = 1'b1; h1.challenge_in = 32'h5555_AAAA;
    @(posedge clk);
    #1 h1.start = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (h1.rsp_valid !== 1'b1 && n < 400);
    chk("tie_latency", n, 32'd84);
    chk("tie_rsp", 32'(h1.rsp), 32'd0);
    chk("tie_ones", 32'(h1.ones_count), 32'd2);
    chk("tie_unstable", 32'(h1.unstable), 32'd1);
    chk("tie_ring_chal", r1_chal, 32'h5555_AAAA);
    @(negedge clk);
    h1.rsp_ready = 1'b1;
    @(posedge clk);
    #1 h1.rsp_ready = 1'b0;
    chk("tie_back_ready", 32'(h1.ready), 32'd1);

    // start during SETTLE is ignored; DONE holds while rsp_ready low
    set_pat0(5'b11111);
    accept0(32'h1234_5678);
    repeat (9) @(posedge clk);
    #1 chk("in_settle", 32'(r0_reset), 32'd0);
    accept0(32'hFFFF_FFFF);
    chk("busy_ready", 32'(h0.ready), 32'd0);
    wait_valid0(n, fall);
    chk("busy_latency", n, 32'd95);
    chk("busy_ring_chal", r0_chal, 32'h1234_5678);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(h0.rsp_valid), 32'd1);
      chk("hold_rsp", 32'(h0.rsp), 32'd1);
    end
    chk("hold_ones", 32'(h0.ones_count), 32'd5);
    chk("hold_ring_chal", r0_chal, 32'h1234_5678);
    release0();
    chk("hold_back_ready", 32'(h0.ready), 32'd1);
    chk("hold_back_valid", 32'(h0.rsp_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 chk("no_queued_start", 32'(h0.ready), 32'd1);
    end

    // reset during the third evaluation
    set_pat0(5'b11111);
    accept0(32'hDEAD_BEEF);
    repeat (46) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("mid_rst_ready", 32'(h0.ready), 32'd1);
    chk("mid_rst_ring_reset", 32'(r0_reset), 32'd1);
    chk("mid_rst_valid", 32'(h0.rsp_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1 chk("mid_rst_no_rsp", 32'(h0.rsp_valid), 32'd0);
    set_pat0(5'b10000);
    accept0(32'hCAFE_0042);
    wait_valid0(n, fall);
    chk("fresh_latency", n, 32'd105);
    chk("fresh_ones", 32'(h0.ones_count), 32'd1);
    chk("fresh_rsp", 32'(h0.rsp), 32'd0);
    chk("fresh_unstable", 32'(h0.unstable), 32'd1);
    chk("fresh_ring_chal", r0_chal, 32'hCAFE_0042);
    release0();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/brpuf_eval_ctrl.md
# brpuf_eval_ctrl

Evaluation sequencer for the 32-stage bistable-ring PUF (`ring`).
- Accepts a 32-bit challenge over a valid/ready handshake.
- Drives the ring's `challenge` and `reset` inputs through a reset/settle/sample cycle, repeated `NUM_EVAL` times.
- Synchronises the asynchronous ring output and majority-votes the samples.
- Returns one response bit plus a stability indication.
- Sits between the host/register interface and the ring instance. It is the only agent that drives the ring.

## Interface
Parameters:
- `CW`, 32, challenge width; must equal ring challenge width.
- `RESET_CYCLES`, 4, cycles `ring_reset` is held high per evaluation; ≥1.
- `SETTLE_CYCLES`, 16, cycles after reset release before sampling; ≥3 (covers the 2-flop synchroniser).
- `NUM_EVAL`, 5, evaluations per challenge; ≥1; odd recommended.

Ports:
- One clock; reset is synchronous and active-high.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  challenge request valid.
- `challenge_in`  in  CW  challenge; sampled when `start & ready`.
- `ready`  out  1  high only in IDLE.
- `rsp_valid`  out  1  result valid; held until `rsp_ready`.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp`  out  1  majority-voted response.
- `ones_count`  out  $clog2(NUM_EVAL+1)  number of samples equal to 1.
- `unstable`  out  1  high when `ones_count` ∉ {0, NUM_EVAL}.
- `ring_challenge`  out  CW  to `ring.challenge`; registered.
- `ring_reset`  out  1  to `ring.reset`; registered.
- `ring_rsp`  in  1  from `ring.rsp`; asynchronous.

## Operation
States and transitions:
- IDLE:
  - `ready`=1 and `ring_reset`=1, so the ring is quiescent.
  - On `start`: latch `challenge_in` into `ring_challenge`, clear the eval and ones counters, go to RST.
- RST:
  - `ring_reset`=1 for `RESET_CYCLES` cycles, then go to SETTLE.
- SETTLE:
  - `ring_reset`=0 for `SETTLE_CYCLES` cycles, then go to SAMPLE.
- SAMPLE (1 cycle):
  - Add the synchronised `ring_rsp` to the ones counter and increment the eval counter.
  - If evals < `NUM_EVAL`, go to RST.
  - Otherwise register `rsp`, `ones_count` and `unstable` (using the updated count) and go to DONE.
- DONE:
  - `rsp_valid`=1 and `ring_reset`=1.
  - On `rsp_ready`, go to IDLE.

Vote and width rules:
- `rsp` = (2·ones > NUM_EVAL). A tie (even `NUM_EVAL`) resolves to 0.
- Counters are sized to hold `NUM_EVAL` exactly and never wrap.

Boundary conditions:
- `start` outside IDLE is ignored; it is not queued.
- `ring_challenge` is stable from the latch until the next accepted `start`, including through DONE.
- `rsp`, `ones_count` and `unstable` hold their value until the next DONE.
- `reset` mid-evaluation:
  - Next edge enters IDLE, and any partial result is discarded.
  - `rsp_valid` goes low; no response is emitted.
- `rsp_ready` while not in DONE has no effect.

## Timing
Reset values:
- State IDLE, `ready`=1, `rsp_valid`=0, `rsp`=0, `ones_count`=0, `unstable`=0.
- `ring_challenge`=0, `ring_reset`=1, synchroniser flops 0.

Cycle timing:
- Latency from the accepting edge to `rsp_valid` high is `NUM_EVAL·(RESET_CYCLES+SETTLE_CYCLES+1)` cycles. With defaults this is 105.
- Back-to-back operation:
  - DONE→IDLE takes one edge after `rsp_ready`.
  - The earliest next accept is the edge after that, so there is a minimum of one IDLE cycle.
- `ring_reset` falls on the first SETTLE cycle.
- The sample uses the synchroniser output at the SAMPLE edge, i.e. the ring state from 2 cycles earlier.

## Structure
- Package `brpuf_pkg`:
  - state enum {IDLE, RST, SETTLE, SAMPLE, DONE};
  - default parameter constants;
  - `CW` localparam.
- Sub-module `sync2`: 2-flop synchroniser for `ring_rsp`. Synchronous reset to 0; the flops are marked keep.
- One shared down-counter serves both the RST and SETTLE phases; it is reloaded on each phase entry.

## Test plan
- Reset release:
  - Outputs take their reset values.
  - `ring_reset`=1 holds for 10 cycles with no `start`.
- Stable-1 ring model, challenge 0xA5A5_A5A5, defaults:
  - `rsp_valid` rises exactly 105 cycles after accept.
  - `rsp`=1, `ones_count`=5, `unstable`=0.
  - `ring_challenge`=0xA5A5_A5A5.
- Ring model returning 1,0,1,0,1 per evaluation:
  - `rsp`=1, `ones_count`=3, `unstable`=1.
- `NUM_EVAL`=4, samples 1,1,0,0:
  - `rsp`=0 (tie), `ones_count`=2.
- `start` pulsed during SETTLE and `rsp_ready` held low for 20 cycles in DONE:
  - The second `start` is ignored.
  - `rsp_valid` and `rsp` are held stable.
  - Return to IDLE 1 cycle after `rsp_ready`.
- `reset` asserted in the 3rd evaluation:
  - Next cycle: IDLE, `ring_reset`=1, `rsp_valid`=0.
  - The following challenge yields a correct, fresh count.
